// File: rtl/sat_up_down_counter.sv
// Saturating up/down counter: holds at MAX on up and at zero on down.
// A simultaneous up and down leaves the count unchanged.
module sat_up_down_counter #(
    parameter int MAX = 15,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic         up,
    input  logic         down,
    output logic [W-1:0] count,
    output logic         at_max
);

    localparam logic [W-1:0] MAX_V  = W'(MAX);
    localparam logic [W-1:0] ZERO_V = '0;
    localparam logic [W-1:0] ONE_V  = W'(1);

    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;

    // The bounds checks are what keep the count from wrapping in either direction.
    always_comb begin
        count_next = count_reg;
        if (enable) begin
            if (up && !down && (count_reg != MAX_V)) begin
                count_next = count_reg + ONE_V;
            end else if (down && !up && (count_reg != ZERO_V)) begin
                count_next = count_reg - ONE_V;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= ZERO_V;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count  = count_reg;
    assign at_max = (count_reg == MAX_V);

endmodule

// File: rtl/pulse_event_queue.sv
// Event queue that counts single-cycle pulses and hands them out through a
// valid/ready port. The pending count is the only storage; drops set a sticky overflow.
module pulse_event_queue #(
    parameter int DEPTH = 15,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          in_pulse,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] pending,
    output logic          overflow,
    input  logic          clear
);

    logic [CW-1:0] cnt;
    logic          at_max;
    logic          inc;
    logic          dec;
    logic          overflow_reg;
    logic          overflow_next;

    // out_valid depends only on the count register and enable, never on in_pulse.
    assign out_valid = (cnt != '0) && enable;
    assign inc       = enable && in_pulse;
    assign dec       = out_valid && out_ready;

    sat_up_down_counter #(
        .MAX (DEPTH),
        .W   (CW)
    ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .up     (inc),
        .down   (dec),
        .count  (cnt),
        .at_max (at_max)
    );

    // A drop only happens on an unmatched increment at full; setting beats clear.
    always_comb begin
        overflow_next = overflow_reg;
        if (inc && !dec && at_max) begin
            overflow_next = 1'b1;
        end else if (clear) begin
            overflow_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_reg <= 1'b0;
        end else begin
            overflow_reg <= overflow_next;
        end
    end

    assign pending  = cnt;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_pulse_event_queue.sv
// Directed checks on a DEPTH=15 queue plus a randomized scoreboard run on a DEPTH=4 queue.
module tb_pulse_event_queue;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DEPTH = 15 instance
    logic       rst_a = 1'b1, en_a = 1'b0, pulse_a = 1'b0, ready_a = 1'b0, clear_a = 1'b0;
    logic       valid_a, ovf_a;
    logic [3:0] pend_a;

    // DEPTH = 4 instance
    logic       rst_b = 1'b1, en_b = 1'b0, pulse_b = 1'b0, ready_b = 1'b0, clear_b = 1'b0;
    logic       valid_b, ovf_b;
    logic [2:0] pend_b;

    int n_vec  = 0;
    int n_fail = 0;

    pulse_event_queue #(.DEPTH(15)) dut_a (
        .clk(clk), .rst(rst_a), .enable(en_a), .in_pulse(pulse_a), .out_valid(valid_a),
        .out_ready(ready_a), .pending(pend_a), .overflow(ovf_a), .clear(clear_a)
    );

    pulse_event_queue #(.DEPTH(4)) dut_b (
        .clk(clk), .rst(rst_b), .enable(en_b), .in_pulse(pulse_b), .out_valid(valid_b),
        .out_ready(ready_b), .pending(pend_b), .overflow(ovf_b), .clear(clear_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp, input bit quiet);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
        if (!quiet) $display("check %-22s observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic chk_a(input string tag, input int p, input int v, input int o);
        chk({tag, ".pending"},   int'(pend_a),  p, 1'b0);
        chk({tag, ".out_valid"}, int'(valid_a), v, 1'b0);
        chk({tag, ".overflow"},  int'(ovf_a),   o, 1'b0);
    endtask

    int hs;
    int m_cnt, m_ovf, total, accepted, dropped;
    bit m_inc, m_dec;

    initial begin
        // Reset
        rst_a = 1'b1; rst_b = 1'b1;
        step();
        step();
        rst_a = 1'b0;
        chk_a("reset", 0, 0, 0);

        // Three back-to-back pulses, no ready
        en_a = 1'b1; pulse_a = 1'b1;
        step(); chk_a("pulse1", 1, 1, 0);
        step(); chk_a("pulse2", 2, 1, 0);
        step(); chk_a("pulse3", 3, 1, 0);
        pulse_a = 1'b0;

        // Drain with ready, counting handshakes
        ready_a = 1'b1; hs = 0;
        for (int i = 0; i < 3; i++) begin
            if (valid_a && ready_a) hs++;
            step();
            chk_a($sformatf("drain%0d", i), 2 - i, (i < 2) ? 1 : 0, 0);
        end
        if (valid_a && ready_a) hs++;
        step();
        chk("no_underflow", int'(pend_a), 0, 1'b0);
        chk("handshakes", hs, 3, 1'b0);
        ready_a = 1'b0;

        // Fill to full, then one dropped pulse
        pulse_a = 1'b1;
        for (int i = 0; i < 15; i++) step();
        chk_a("full", 15, 1, 0);
        step(); chk_a("drop", 15, 1, 1);
        ready_a = 1'b1;
        step(); chk_a("full_inc_dec", 15, 1, 1);
        pulse_a = 1'b0; ready_a = 1'b0; clear_a = 1'b1;
        step(); chk_a("clear", 15, 1, 0);
        pulse_a = 1'b1;
        step(); chk_a("clear_vs_set", 15, 1, 1);
        pulse_a = 1'b0;
        step(); chk_a("clear2", 15, 1, 0);
        clear_a = 1'b0;

        // Down to 5, then freeze with enable low
        ready_a = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk_a("at5", 5, 1, 0);
        en_a = 1'b0; pulse_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_a($sformatf("frozen%0d", i), 5, 0, 0);
        end
        pulse_a = 1'b0; ready_a = 1'b0; en_a = 1'b1;
        #1;
        chk("reenable.out_valid", int'(valid_a), 1, 1'b0);

        // Reach 7 with overflow set, then reset with a pulse present
        pulse_a = 1'b1;
        for (int i = 0; i < 11; i++) step();
        chk_a("refill", 15, 1, 1);
        pulse_a = 1'b0; ready_a = 1'b1;
        for (int i = 0; i < 8; i++) step();
        chk_a("at7", 7, 1, 1);
        ready_a = 1'b0; pulse_a = 1'b1; rst_a = 1'b1;
        step(); chk_a("mid_reset", 0, 0, 0);
        rst_a = 1'b0; pulse_a = 1'b0;

        // Randomized scoreboard run on the DEPTH=4 instance
        rst_b = 1'b0;
        m_cnt = 0; m_ovf = 0; total = 0; accepted = 0; dropped = 0;
        for (int c = 0; c < 10000; c++) begin
            en_b    = ($urandom_range(7) != 0);
            pulse_b = ($urandom_range(1) != 0);
            ready_b = ($urandom_range(2) == 0);
            clear_b = ($urandom_range(199) == 0);
            #1;
            chk("rand.out_valid", int'(valid_b), int'((m_cnt != 0) && en_b), 1'b1);
            m_inc = en_b && pulse_b;
            m_dec = (m_cnt != 0) && en_b && ready_b;
            if (m_inc) total++;
            if (valid_b && ready_b) accepted++;
            if (m_inc && !m_dec && m_cnt == 4) begin
                dropped++;
                m_ovf = 1;
            end else if (clear_b) begin
                m_ovf = 0;
            end
            if (m_inc && !m_dec && m_cnt < 4) m_cnt++;
            else if (m_dec && !m_inc) m_cnt--;
            @(posedge clk);
            #1;
            chk("rand.pending",  int'(pend_b), m_cnt, 1'b1);
            chk("rand.overflow", int'(ovf_b),  m_ovf, 1'b1);
        end
        chk("rand.conservation", accepted + dropped + int'(pend_b), total, 1'b0);
        $display("random run: %0d pulses, %0d accepted, %0d dropped", total, accepted, dropped);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/pulse_event_queue.md
PULSE_EVENT_QUEUE -- requirements
Module: pulse_event_queue

Interface
REQ-001: Parameter DEPTH, default 15, maximum number of pending events held; legal range 1..255.
REQ-002: Derived constant CW, equal to clog2(DEPTH+1), sets the width of the pending count.
REQ-003: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004: rst  input  1  reset, synchronous and active-high.
REQ-005: enable  input  1  global advance qualifier; low freezes count and handshake.
REQ-006: in_pulse  input  1  single-cycle event pulse, already synchronized to clk (one event per high cycle).
REQ-007: out_valid  output  1  at least one event pending and enable high.
REQ-008: out_ready  input  1  consumer accepts one event when high together with out_valid.
REQ-009: pending  output  CW  current number of stored events.
REQ-010: overflow  output  1  sticky flag, set when an event was dropped because the queue was full.
REQ-011: clear  input  1  synchronous clear of overflow.

Function
REQ-012: Internal count register cnt (CW bits) SHALL be the only event storage; pending SHALL equal cnt directly.
REQ-013: out_valid SHALL equal (cnt != 0) AND enable, combinationally from the register.
REQ-014: Define inc = enable AND in_pulse, dec = out_valid AND out_ready.
REQ-015: inc only, cnt < DEPTH -> cnt+1 at next edge.
REQ-016: dec only -> cnt-1 at next edge; dec cannot occur at cnt 0 since out_valid is low.
REQ-017: inc and dec in the same cycle -> cnt unchanged, no overflow, at any cnt including DEPTH.
REQ-018: inc only at cnt == DEPTH -> cnt stays DEPTH, overflow set to 1 at next edge; event dropped.
REQ-019: cnt SHALL never wrap: no transition from DEPTH to 0 or from 0 to all-ones.
REQ-020: Latency: in_pulse high in cycle N with cnt 0 -> out_valid high in cycle N+1; no combinational path from in_pulse to out_valid.
REQ-021: enable low -> cnt held, in_pulse ignored (not counted, no overflow), out_valid 0, out_ready ignored.
REQ-022: overflow SHALL remain 1 until clear or rst; clear high -> overflow 0 at next edge.
REQ-023: clear and a new overflow condition in the same cycle -> overflow 1 (set wins).
REQ-024: clear SHALL act regardless of enable and SHALL NOT affect cnt.
REQ-025: Back-to-back in_pulse on consecutive cycles SHALL each count as separate events.

Reset
REQ-026: rst high at a clock edge -> cnt 0, overflow 0; hence pending 0 and out_valid 0 in the following cycle.
REQ-027: rst SHALL override inc, dec, clear, and enable in the same cycle; pending events are discarded, and a mid-operation reset loses them without asserting overflow.
REQ-028: No output SHALL be X after the first reset edge.

Structure
REQ-029: No shared package; DEPTH and CW are local to the module, with CW computed from DEPTH.
REQ-030: One sub-module, sat_up_down_counter (parameters MAX, W; ports clk, rst, enable, up, down, count, at_max), holds cnt; the top adds out_valid gating and overflow logic.
REQ-031: All state flops are synchronous-reset on clk; no latches, no other clocks.

Verification
REQ-032: DEPTH=15, rst, then 3 in_pulse on consecutive cycles with out_ready=0 -> pending 1,2,3 on the cycles after each pulse; out_valid high from the cycle after the first pulse.
REQ-033: pending=3, out_ready=1 for 3 cycles with no pulses -> pending 2,1,0; out_valid low after the third accept; exactly 3 handshakes.
REQ-034: pending=15 (full), 1 extra pulse with out_ready=0 -> pending stays 15, overflow 1; then in_pulse and out_ready high together -> pending 15, no extra overflow effect; clear -> overflow 0.
REQ-035: pending=5, enable=0 for 4 cycles with in_pulse=1 and out_ready=1 -> pending 5, out_valid 0, overflow 0; re-enable -> out_valid 1.
REQ-036: pending=7, overflow=1, rst with in_pulse=1 and clear=0 -> next cycle pending 0, overflow 0, out_valid 0.
REQ-037: Random pulses and ready over 10k cycles with DEPTH=4 -> scoreboard: accepted + dropped + final pending = total pulses counted under enable; overflow high iff dropped > 0 since last clear.
